// File: rtl/cp0_exp_regs.sv
// Coprocessor-0 exception/status register file: MFC0/MTC0 access plus exception
// commit and ERET updates, with interrupt and mode state fed back to the prioritiser.
module cp0_exp_regs #(
  parameter logic [31:0] PRID_VALUE  = 32'h0001_8000,
  parameter logic [19:0] EBASE_RESET = 20'h80000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  hw_int,
  input  logic [4:0]  rd_addr,
  input  logic [2:0]  rd_sel,
  output logic [31:0] rd_data,
  input  logic        we,
  input  logic [4:0]  wr_addr,
  input  logic [2:0]  wr_sel,
  input  logic [31:0] wr_data,
  input  logic        cp0_wr_exp,
  input  logic        cp0_clean_exl,
  input  logic [4:0]  exp_code,
  input  logic [31:0] exp_epc,
  input  logic        exp_bd,
  input  logic [31:0] exp_bad_vaddr,
  input  logic        cp0_badv_we,
  input  logic [7:0]  exp_asid,
  input  logic        cp0_exp_asid_we,
  output logic [7:0]  interrupt_flags,
  output logic        allow_int,
  output logic [19:0] ebase_out,
  output logic [31:0] epc_out,
  output logic        special_int_vec,
  output logic        boot_exp_vec,
  output logic        exl,
  output logic [7:0]  asid,
  output logic        user_mode
);

  localparam int unsigned REG_BADV    = 8;
  localparam int unsigned REG_COUNT   = 9;
  localparam int unsigned REG_ENTRYHI = 10;
  localparam int unsigned REG_COMPARE = 11;
  localparam int unsigned REG_STATUS  = 12;
  localparam int unsigned REG_CAUSE   = 13;
  localparam int unsigned REG_EPC     = 14;
  localparam int unsigned REG_PRID    = 15;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0004;
  localparam logic [31:0] STATUS_MASK  = 32'h1040_FF17;
  localparam logic [31:0] ENTRYHI_MASK = 32'hFFFF_E0FF;

  logic [31:0] status_q;
  logic        bd_q;
  logic        ti_q;
  logic        iv_q;
  logic [4:0]  ip_hw_q;
  logic [1:0]  ip_sw_q;
  logic [4:0]  exc_code_q;
  logic [31:0] epc_q;
  logic [31:0] badv_q;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic [31:0] entryhi_q;
  logic [19:0] ebase_q;
  logic        phase_q;

  logic [31:0] cause;
  logic [7:0]  ip;
  logic        wr_count, wr_entryhi, wr_compare, wr_status, wr_cause, wr_epc, wr_ebase;

  always_comb begin
    wr_count   = we && (wr_sel == 3'd0) && (wr_addr == 5'(REG_COUNT));
    wr_entryhi = we && (wr_sel == 3'd0) && (wr_addr == 5'(REG_ENTRYHI));
    wr_compare = we && (wr_sel == 3'd0) && (wr_addr == 5'(REG_COMPARE));
    wr_status  = we && (wr_sel == 3'd0) && (wr_addr == 5'(REG_STATUS));
    wr_cause   = we && (wr_sel == 3'd0) && (wr_addr == 5'(REG_CAUSE));
    wr_epc     = we && (wr_sel == 3'd0) && (wr_addr == 5'(REG_EPC));
    wr_ebase   = we && (wr_sel == 3'd1) && (wr_addr == 5'(REG_PRID));
  end

  // Later non-blocking assignments win, so exception/ERET field updates override MTC0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q   <= STATUS_RESET;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      iv_q       <= 1'b0;
      ip_hw_q    <= 5'd0;
      ip_sw_q    <= 2'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
      badv_q     <= 32'd0;
      count_q    <= 32'd0;
      compare_q  <= 32'd0;
      entryhi_q  <= 32'd0;
      ebase_q    <= EBASE_RESET;
      phase_q    <= 1'b0;
    end else begin
      ip_hw_q <= hw_int;

      if (wr_count) begin
        count_q <= wr_data;
        phase_q <= 1'b0;
      end else begin
        phase_q <= ~phase_q;
        if (phase_q) count_q <= count_q + 32'd1;
      end

      if (wr_compare) begin
        compare_q <= wr_data;
        ti_q      <= 1'b0;
      end else if ((count_q == compare_q) && (compare_q != 32'd0)) begin
        ti_q <= 1'b1;
      end

      if (wr_status)  status_q  <= (status_q & ~STATUS_MASK) | (wr_data & STATUS_MASK);
      if (wr_entryhi) entryhi_q <= (entryhi_q & ~ENTRYHI_MASK) | (wr_data & ENTRYHI_MASK);
      if (wr_epc)     epc_q     <= wr_data;
      if (wr_ebase)   ebase_q   <= {2'b10, wr_data[29:12]};
      if (wr_cause) begin
        iv_q    <= wr_data[23];
        ip_sw_q <= wr_data[9:8];
      end

      if (cp0_wr_exp) begin
        status_q[1] <= 1'b1;
        exc_code_q  <= exp_code;
        if (!status_q[1]) begin
          epc_q <= exp_epc;
          bd_q  <= exp_bd;
        end
        if (cp0_badv_we)     badv_q    <= exp_bad_vaddr;
        if (cp0_exp_asid_we) entryhi_q <= {exp_bad_vaddr[31:13], 5'b0, exp_asid};
      end else if (cp0_clean_exl) begin
        if (status_q[2]) status_q[2] <= 1'b0;
        else             status_q[1] <= 1'b0;
      end
    end
  end

  always_comb begin
    ip    = {ti_q, ip_hw_q, ip_sw_q};
    cause = {bd_q, ti_q, 6'b0, iv_q, 7'b0, ip, 1'b0, exc_code_q, 2'b0};
  end

  // MFC0 read mux; unmapped register/select pairs read as zero.
  always_comb begin
    rd_data = 32'd0;
    if (rd_sel == 3'd0) begin
      case (rd_addr)
        5'(REG_BADV):    rd_data = badv_q;
        5'(REG_COUNT):   rd_data = count_q;
        5'(REG_ENTRYHI): rd_data = entryhi_q;
        5'(REG_COMPARE): rd_data = compare_q;
        5'(REG_STATUS):  rd_data = status_q;
        5'(REG_CAUSE):   rd_data = cause;
        5'(REG_EPC):     rd_data = epc_q;
        5'(REG_PRID):    rd_data = PRID_VALUE;
        default:         rd_data = 32'd0;
      endcase
    end else if ((rd_sel == 3'd1) && (rd_addr == 5'(REG_PRID))) begin
      rd_data = {ebase_q, 12'h000};
    end
  end

  always_comb begin
    interrupt_flags = ip & status_q[15:8];
    allow_int       = status_q[0] & ~status_q[1] & ~status_q[2];
    user_mode       = status_q[4] & ~status_q[1] & ~status_q[2];
    ebase_out       = ebase_q;
    epc_out         = epc_q;
    special_int_vec = iv_q;
    boot_exp_vec    = status_q[22];
    exl             = status_q[1];
    asid            = entryhi_q[7:0];
  end

endmodule

// File: tb/tb_cp0_exp_regs.sv
// Directed bench for cp0_exp_regs: register access, masks, exception/ERET commit,
// Count/Compare timer and asynchronous reset, against hand-computed values.
module tb_cp0_exp_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  hw_int;
  logic [4:0]  rd_addr;
  logic [2:0]  rd_sel;
  logic [31:0] rd_data;
  logic        we;
  logic [4:0]  wr_addr;
  logic [2:0]  wr_sel;
  logic [31:0] wr_data;
  logic        cp0_wr_exp;
  logic        cp0_clean_exl;
  logic [4:0]  exp_code;
  logic [31:0] exp_epc;
  logic        exp_bd;
  logic [31:0] exp_bad_vaddr;
  logic        cp0_badv_we;
  logic [7:0]  exp_asid;
  logic        cp0_exp_asid_we;
  logic [7:0]  interrupt_flags;
  logic        allow_int;
  logic [19:0] ebase_out;
  logic [31:0] epc_out;
  logic        special_int_vec;
  logic        boot_exp_vec;
  logic        exl;
  logic [7:0]  asid;
  logic        user_mode;

  int ntests = 0;
  int nfail  = 0;
  logic [31:0] v0, v1;

  cp0_exp_regs dut (
    .clk(clk), .rst(rst), .hw_int(hw_int),
    .rd_addr(rd_addr), .rd_sel(rd_sel), .rd_data(rd_data),
    .we(we), .wr_addr(wr_addr), .wr_sel(wr_sel), .wr_data(wr_data),
    .cp0_wr_exp(cp0_wr_exp), .cp0_clean_exl(cp0_clean_exl),
    .exp_code(exp_code), .exp_epc(exp_epc), .exp_bd(exp_bd),
    .exp_bad_vaddr(exp_bad_vaddr), .cp0_badv_we(cp0_badv_we),
    .exp_asid(exp_asid), .cp0_exp_asid_we(cp0_exp_asid_we),
    .interrupt_flags(interrupt_flags), .allow_int(allow_int),
    .ebase_out(ebase_out), .epc_out(epc_out),
    .special_int_vec(special_int_vec), .boot_exp_vec(boot_exp_vec),
    .exl(exl), .asid(asid), .user_mode(user_mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a, input logic [2:0] s, output logic [31:0] d);
    rd_addr = a;
    rd_sel  = s;
    #1;
    d = rd_data;
  endtask

  // Drive for exactly one rising edge; returns just after that edge.
  task automatic mtc0(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; wr_addr = a; wr_sel = s; wr_data = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic commit(input logic ex, input logic eret, input logic [4:0] code,
                        input logic [31:0] epc, input logic bd, input logic [31:0] badv,
                        input logic bwe, input logic [7:0] as, input logic awe);
    @(negedge clk);
    cp0_wr_exp = ex; cp0_clean_exl = eret; exp_code = code; exp_epc = epc;
    exp_bd = bd; exp_bad_vaddr = badv; cp0_badv_we = bwe; exp_asid = as;
    cp0_exp_asid_we = awe;
    @(posedge clk); #1;
    cp0_wr_exp = 1'b0; cp0_clean_exl = 1'b0; cp0_badv_we = 1'b0; cp0_exp_asid_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; hw_int = '0; rd_addr = '0; rd_sel = '0; we = 1'b0; wr_addr = '0;
    wr_sel = '0; wr_data = '0; cp0_wr_exp = 1'b0; cp0_clean_exl = 1'b0; exp_code = '0;
    exp_epc = '0; exp_bd = 1'b0; exp_bad_vaddr = '0; cp0_badv_we = 1'b0; exp_asid = '0;
    cp0_exp_asid_we = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    rd(5'd12, 3'd0, v0); check("rst_status", v0, 32'h0040_0004);
    rd(5'd15, 3'd1, v0); check("rst_ebase", v0, 32'h8000_0000);
    rd(5'd15, 3'd0, v0); check("prid", v0, 32'h0001_8000);
    rd(5'd13, 3'd0, v0); check("rst_cause", v0, 32'h0);
    check("rst_allow_int", 32'(allow_int), 32'd0);
    check("rst_bev", 32'(boot_exp_vec), 32'd1);
    check("rst_iflags", 32'(interrupt_flags), 32'd0);
    check("rst_ebase_out", 32'(ebase_out), 32'h80000);

    // Count advances once per two cycles
    rd(5'd9, 3'd0, v0);
    repeat (2) @(posedge clk);
    #1; rd(5'd9, 3'd0, v1); check("count_rate", v1, v0 + 32'd1);

    mtc0(5'd13, 3'd0, 32'hFFFF_FFFF);
    rd(5'd13, 3'd0, v0); check("cause_mask", v0, 32'h0080_0300);
    check("iv_out", 32'(special_int_vec), 32'd1);
    check("sw_ip_masked", 32'(interrupt_flags), 32'd0);
    mtc0(5'd13, 3'd0, 32'h0);

    commit(1'b1, 1'b0, 5'h0c, 32'h8000_1004, 1'b1, 32'h0, 1'b0, 8'h0, 1'b0);
    rd(5'd14, 3'd0, v0); check("exc1_epc", v0, 32'h8000_1004);
    check("exc1_epc_out", epc_out, 32'h8000_1004);
    rd(5'd13, 3'd0, v0); check("exc1_cause", v0, 32'h8000_0030);
    check("exc1_exl", 32'(exl), 32'd1);

    commit(1'b1, 1'b0, 5'h04, 32'h8000_2000, 1'b0, 32'h0, 1'b0, 8'h0, 1'b0);
    rd(5'd14, 3'd0, v0); check("exc2_epc_kept", v0, 32'h8000_1004);
    rd(5'd13, 3'd0, v0); check("exc2_cause", v0, 32'h8000_0010);

    commit(1'b1, 1'b0, 5'h02, 32'h0, 1'b0, 32'h1234_5678, 1'b1, 8'h3a, 1'b1);
    rd(5'd8, 3'd0, v0);  check("tlb_badv", v0, 32'h1234_5678);
    rd(5'd10, 3'd0, v0); check("tlb_entryhi", v0, 32'h1234_403a);
    check("tlb_asid", 32'(asid), 32'h3a);

    mtc0(5'd8, 3'd0, 32'hDEAD_BEEF);
    rd(5'd8, 3'd0, v0); check("badv_ro", v0, 32'h1234_5678);

    mtc0(5'd12, 3'd0, 32'h0000_0003);
    check("pre_eret_allow", 32'(allow_int), 32'd0);
    commit(1'b0, 1'b1, 5'h0, 32'h0, 1'b0, 32'h0, 1'b0, 8'h0, 1'b0);
    check("eret_exl", 32'(exl), 32'd0);
    check("eret_allow", 32'(allow_int), 32'd1);
    rd(5'd12, 3'd0, v0); check("eret_status", v0, 32'h0000_0001);
    commit(1'b1, 1'b1, 5'h08, 32'h8000_3000, 1'b0, 32'h0, 1'b0, 8'h0, 1'b0);
    check("exc_over_eret_exl", 32'(exl), 32'd1);
    check("exc_over_eret_epc", epc_out, 32'h8000_3000);

    // ERET with ERL set clears ERL only
    mtc0(5'd12, 3'd0, 32'h0000_0006);
    commit(1'b0, 1'b1, 5'h0, 32'h0, 1'b0, 32'h0, 1'b0, 8'h0, 1'b0);
    rd(5'd12, 3'd0, v0); check("eret_erl", v0, 32'h0000_0002);

    mtc0(5'd12, 3'd0, 32'h0000_8001);
    check("timer_allow", 32'(allow_int), 32'd1);
    mtc0(5'd9, 3'd0, 32'd0);
    mtc0(5'd11, 3'd0, 32'd10);
    mtc0(5'd9, 3'd0, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("timer_pre", 32'(interrupt_flags), 32'h00);
    rd(5'd9, 3'd0, v0); check("timer_count", v0, 32'd10);
    @(posedge clk); #1;
    check("timer_fire", 32'(interrupt_flags), 32'h80);
    check("timer_allow2", 32'(allow_int), 32'd1);
    mtc0(5'd11, 3'd0, 32'd10);
    check("timer_clear", 32'(interrupt_flags), 32'h00);

    // Compare write on the matching edge wins; match recurs next edge
    mtc0(5'd9, 3'd0, 32'd10);
    mtc0(5'd11, 3'd0, 32'd10);
    check("clear_wins", 32'(interrupt_flags), 32'h00);
    @(posedge clk); #1;
    check("rematch", 32'(interrupt_flags), 32'h80);
    mtc0(5'd11, 3'd0, 32'd0);
    check("cmp_zero", 32'(interrupt_flags), 32'h00);

    mtc0(5'd12, 3'd0, 32'h0000_1001);
    @(negedge clk);
    hw_int = 5'b00100;
    #1; check("hw_int_latency", 32'(interrupt_flags), 32'h00);
    @(posedge clk); #1;
    check("hw_int_flag", 32'(interrupt_flags), 32'h10);
    hw_int = 5'b00000;

    mtc0(5'd12, 3'd0, 32'h0000_0010);
    check("user_mode", 32'(user_mode), 32'd1);
    mtc0(5'd12, 3'd0, 32'h0000_0012);
    check("user_mode_exl", 32'(user_mode), 32'd0);

    mtc0(5'd9, 3'd0, 32'hFFFF_FFFF);
    rd(5'd9, 3'd0, v0); check("count_load", v0, 32'hFFFF_FFFF);
    repeat (2) @(posedge clk);
    #1; rd(5'd9, 3'd0, v0); check("count_wrap", v0, 32'h0);

    mtc0(5'd15, 3'd1, 32'hFFFF_FFFF);
    rd(5'd15, 3'd1, v0); check("ebase_mask", v0, 32'hBFFF_F000);
    check("ebase_out", 32'(ebase_out), 32'hBFFFF);

    mtc0(5'd5, 3'd0, 32'h1234_5678);
    rd(5'd5, 3'd0, v0);  check("unmapped_5", v0, 32'h0);
    rd(5'd12, 3'd1, v0); check("unmapped_12_1", v0, 32'h0);

    // Asynchronous reset mid-cycle
    #2; rst = 1'b1;
    rd(5'd12, 3'd0, v0); check("arst_status", v0, 32'h0040_0004);
    check("arst_ebase", 32'(ebase_out), 32'h80000);
    check("arst_epc", epc_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/cp0_exp_regs.md
Name: cp0_exp_regs

Overview:
- Coprocessor-0 register file that receives the MM-stage exception prioritiser's commit outputs.
- Holds Status, Cause, EPC, BadVAddr, Count/Compare, EntryHi and EBase, and services MFC0/MTC0.
- Feeds interrupt, exception-vector and mode state back to the prioritiser: interrupt_flags, allow_int, ebase, epc, vector selects and EXL/ASID.

Parameters:
PRID_VALUE, 32'h00018000, read-only value returned for PRId (reg 15 sel 0)
EBASE_RESET, 20'h80000, reset value of EBase[31:12]

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
hw_int  in  5  external interrupt lines, mapped to Cause.IP[6:2]
rd_addr  in  5  MFC0 register number
rd_sel  in  3  MFC0 select
rd_data  out  32  MFC0 read data, combinational from current register state
we  in  1  MTC0 write strobe
wr_addr  in  5  MTC0 register number
wr_sel  in  3  MTC0 select
wr_data  in  32  MTC0 write data
cp0_wr_exp  in  1  commit exception this cycle
cp0_clean_exl  in  1  ERET: clear EXL
exp_code  in  5  ExcCode to record
exp_epc  in  32  restart PC, already delay-slot adjusted
exp_bd  in  1  faulting instruction is in a delay slot
exp_bad_vaddr  in  32  faulting virtual address
cp0_badv_we  in  1  update BadVAddr
exp_asid  in  8  ASID of faulting access
cp0_exp_asid_we  in  1  update EntryHi VPN2/ASID
interrupt_flags  out  8  Cause.IP & Status.IM
allow_int  out  1  Status.IE & !EXL & !ERL
ebase_out  out  20  EBase[31:12]
epc_out  out  32  EPC
special_int_vec  out  1  Cause.IV
boot_exp_vec  out  1  Status.BEV
exl  out  1  Status.EXL
asid  out  8  EntryHi.ASID
user_mode  out  1  Status.UM & !EXL & !ERL

Behaviour:
- Reset values (async, rst high):
  - Status = 32'h0040_0004 (BEV=1, ERL=1); Cause = 0; EPC = 0; BadVAddr = 0; Count = 0; Compare = 0; EntryHi = 0; EBase = {EBASE_RESET, 12'h0}.
  - A reset-phase register also clears to 0.
  - Resulting outputs: interrupt_flags = 0, allow_int = 0, boot_exp_vec = 1.
- Register map (reg/sel 0): 8 BadVAddr (RO), 9 Count, 10 EntryHi, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 PRId (RO). Reg 15 sel 1 is EBase.
  - Unmapped addresses read 0 and ignore writes.
- Write masks:
  - Status: writable bits 28, 22, 15:8, 4, 2:0.
  - Cause: only IV (bit 23) and IP[1:0] writable.
  - EntryHi: bits 31:13 and 7:0 writable.
  - EBase: bits 29:12 writable; 31:30 stay 2'b10.
- All writes take effect at the next rising edge. Outputs reflect the new value from that edge. There is no write-to-read bypass.
- Count:
  - Increments by 1 every second cycle; the phase register toggles every cycle and Count increments when phase=1.
  - Wraps 32'hFFFF_FFFF -> 0.
  - An MTC0 to Count loads wr_data and clears the phase.
- Timer interrupt (Cause.IP[7]/TI):
  - Set on the edge after Count == Compare while Compare != 0.
  - Stays set until an MTC0 to Compare, which clears it in the same edge.
- Cause.IP[6:2] is hw_int registered once per cycle (1-cycle latency). interrupt_flags is combinational from the registers.
- Exception commit (cp0_wr_exp=1), at the edge:
  - If EXL=0: EPC <= exp_epc and Cause.BD <= exp_bd.
  - If EXL=1: EPC and BD are unchanged.
  - Always: EXL <= 1 and Cause.ExcCode <= exp_code.
  - cp0_badv_we=1: BadVAddr <= exp_bad_vaddr.
  - cp0_exp_asid_we=1: EntryHi <= {exp_bad_vaddr[31:13], 5'b0, exp_asid}.
- ERET (cp0_clean_exl=1): EXL <= 0. If ERL=1, ERL <= 0 instead and EXL is unchanged.
- Simultaneous events:
  - cp0_wr_exp has priority over cp0_clean_exl.
  - Exception/ERET updates to a field override an MTC0 to the same register field in that cycle. An MTC0 to other fields of that register is applied.
  - An MTC0 to Compare in the same cycle Count matches: the clear wins.
- Reset asserted mid-operation returns all state to reset values immediately. No write in flight survives.

Test Plan:
- Reset: after rst, read reg 12 -> 32'h0040_0004; reg 15 sel 1 -> 32'h8000_0000; allow_int=0, boot_exp_vec=1.
- Exception with EXL=0: exp_epc=32'h8000_1004, exp_bd=1, exp_code=5'h0c -> EPC=32'h8000_1004, Cause.BD=1, Cause[6:2]=5'h0c, exl=1. Then a second exception with exp_epc=32'h8000_2000 -> EPC unchanged, ExcCode updated.
- TLB miss commit: exp_bad_vaddr=32'h1234_5678, exp_asid=8'h3a, both we=1 -> BadVAddr=32'h1234_5678, EntryHi=32'h1234_403a, asid=8'h3a.
- Timer: MTC0 Compare=10, Count=0 -> TI sets once Count reaches 10 (~20 cycles). With Status=32'h0000_8001: interrupt_flags=8'h80, allow_int=1. MTC0 Compare -> interrupt_flags=0.
- ERET: Status=32'h0000_0003 (EXL=1, IE=1) plus clean_exl -> exl=0, allow_int=1. Same cycle as cp0_wr_exp -> exl stays 1.
- Masking/RO: MTC0 Cause=32'hFFFF_FFFF -> reads 32'h0080_0300 (with no interrupts pending); MTC0 BadVAddr -> unchanged.
